// File: rtl/sub_bytes_arbiter_if.sv
// Request/response bundle between the two SubBytes requesters and the shared arbiter.
interface sub_bytes_arbiter_if #(
  parameter int DATA_LEN = 128,
  parameter int KEY_LEN  = 32
);
  logic                s_valid;
  logic                s_ready;
  logic [DATA_LEN-1:0] s_data;
  logic                k_valid;
  logic                k_ready;
  logic [KEY_LEN-1:0]  k_data;
  logic                s_rsp_valid;
  logic                k_rsp_valid;
  logic [DATA_LEN-1:0] rsp_data;
  logic                busy;
  logic                timeout_err;

  modport master (
    output s_valid, s_data, k_valid, k_data,
    input  s_ready, k_ready, s_rsp_valid, k_rsp_valid, rsp_data, busy, timeout_err
  );

  modport slave (
    input  s_valid, s_data, k_valid, k_data,
    output s_ready, k_ready, s_rsp_valid, k_rsp_valid, rsp_data, busy, timeout_err
  );
endinterface

// File: rtl/sub_bytes_arbiter.sv
// One registered SubBytes block shared round-robin between the round state and the
// key-expansion word, one operation in flight, with a watchdog on the result.
module sub_bytes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset of entry a is 8*(255-a) = {~a, 3'b0}.
  logic [10:0] idx;
  assign idx = {~a_i, 3'b000};
  assign y_o = SBOX[idx +: 8];
endmodule

module sub_bytes #(
  parameter int DATA_LEN = 128
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_in_i,
  input  logic [DATA_LEN-1:0] data_in_i,
  output logic                valid_out_o,
  output logic [DATA_LEN-1:0] data_out_o
);
  localparam int NUM_LANES = DATA_LEN / 8;
  localparam int STAGES    = 1;

  logic [NUM_LANES-1:0][7:0] din, sub_d, data_q;
  logic [STAGES:0]           vld_pipe;
  logic                      vld_q;

  assign din      = data_in_i;
  assign vld_pipe = {vld_q, valid_in_i};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sub_bytes_sbox u_sbox (.a_i(din[l]), .y_o(sub_d[l]));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= vld_pipe[0];
      if (vld_pipe[0]) data_q <= sub_d;
    end
  end

  assign valid_out_o = vld_pipe[STAGES];
  assign data_out_o  = data_q;
endmodule

module sub_bytes_arbiter #(
  parameter int DATA_LEN = 128,
  parameter int KEY_LEN  = 32,
  parameter int TIMEOUT  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  sub_bytes_arbiter_if.slave   bus
);
  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic       {OWN_S, OWN_K}      owner_e;

  typedef struct packed {
    owner_e              owner;
    logic [DATA_LEN-1:0] data;
  } op_t;

  state_e              state_q, state_d;
  owner_e              last_q, last_d;
  op_t                 op_q, op_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
  logic                s_rsp_q, s_rsp_d, k_rsp_q, k_rsp_d, to_q, to_d;
  logic                grant_s, grant_k;
  logic                sb_vld_in, sb_vld_out;
  logic [DATA_LEN-1:0] sb_data_out;

  sub_bytes #(.DATA_LEN(DATA_LEN)) u_sub_bytes (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_in_i  (sb_vld_in),
    .data_in_i   (op_q.data),
    .valid_out_o (sb_vld_out),
    .data_out_o  (sb_data_out)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    s_rsp_d    = 1'b0;
    k_rsp_d    = 1'b0;
    to_d       = 1'b0;
    grant_s    = 1'b0;
    grant_k    = 1'b0;
    sb_vld_in  = 1'b0;
    case (state_q)
      IDLE: begin
        // Readies are held low while reset is asserted so nothing looks accepted.
        grant_s = reset_i && bus.s_valid && (!bus.k_valid || last_q == OWN_K);
        grant_k = reset_i && bus.k_valid && (!bus.s_valid || last_q == OWN_S);
        if (grant_s) begin
          op_d    = '{owner: OWN_S, data: bus.s_data};
          last_d  = OWN_S;
          state_d = ISSUE;
        end else if (grant_k) begin
          op_d    = '{owner: OWN_K, data: {{(DATA_LEN-KEY_LEN){1'b0}}, bus.k_data}};
          last_d  = OWN_K;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sb_vld_in = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A result landing on the watchdog's last cycle still wins.
        if (sb_vld_out) begin
          rsp_data_d = sb_data_out;
          s_rsp_d    = (op_q.owner == OWN_S);
          k_rsp_d    = (op_q.owner == OWN_K);
          state_d    = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      last_q     <= OWN_K;
      op_q       <= '{owner: OWN_S, data: '0};
      cnt_q      <= '0;
      rsp_data_q <= '0;
      s_rsp_q    <= 1'b0;
      k_rsp_q    <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      s_rsp_q    <= s_rsp_d;
      k_rsp_q    <= k_rsp_d;
      to_q       <= to_d;
    end
  end

  assign bus.s_ready     = grant_s;
  assign bus.k_ready     = grant_k;
  assign bus.s_rsp_valid = s_rsp_q;
  assign bus.k_rsp_valid = k_rsp_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = to_q;
endmodule
